// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a program in instruction memory from
// address 0 to last_add and latches each instruction into ir. It honours
// stalls and branches, and halts after the final instruction.
module fetch_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power,
    input  logic [ADDR_W-1:0] last_add,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_add,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  instr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LATCH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic [CNT_W-1:0]  cnt_q;

    // Sequencer FSM with pc, instruction register and retire counter.
    // Dropping power returns to IDLE from any active state. It takes priority
    // over stall and branch, and the instruction in flight is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ir_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pc_q  <= '0;
                    cnt_q <= '0;
                    if (power) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!power) begin
                        state_q <= S_IDLE;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                    end else if (!stall) begin
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (!power) begin
                        state_q <= S_IDLE;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                    end else if (!stall) begin
                        ir_q       <= mem_data;
                        ir_valid_q <= 1'b1;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (branch_en) begin
                            pc_q    <= branch_add;
                            state_q <= S_FETCH;
                        end else if (pc_q == last_add) begin
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= pc_q + ADDR_W'(1);
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (!power) begin
                        state_q <= S_IDLE;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers or from a decode of the state register.
    assign mem_add   = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign instr_cnt = cnt_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_LATCH);
    assign done      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a program-level reference model is checked against
// the DUT every cycle, with directed programs and then randomized control.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       power = 1'b0;
    logic [7:0] last_add = 8'd0;
    logic       stall = 1'b0;
    logic       branch_en = 1'b0;
    logic [7:0] branch_add = 8'd0;
    logic [7:0] mem_data = 8'd0;

    logic [7:0]  mem_add, ir, mem_add_s, ir_s;
    logic        ir_valid, busy, done, ir_valid_s, busy_s, done_s;
    logic [15:0] instr_cnt;
    logic [1:0]  instr_cnt_s;

    logic [7:0] mem [256];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state: phase 0 idle, 1 address out, 2 data ready, 3 halted.
    int         m_ph = 0;
    logic [7:0] m_pc = 8'd0;
    logic [7:0] m_ir = 8'd0;
    bit         m_v = 1'b0;
    int         m_cnt = 0;

    logic [7:0] log_add [16];
    logic [7:0] log_ir  [16];
    int         log_cyc [16];
    int         log_n;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .power(power), .last_add(last_add),
        .stall(stall), .branch_en(branch_en), .branch_add(branch_add),
        .mem_data(mem_data), .mem_add(mem_add), .ir(ir), .ir_valid(ir_valid),
        .busy(busy), .done(done), .instr_cnt(instr_cnt)
    );

    fetch_sequencer #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .power(power), .last_add(last_add),
        .stall(stall), .branch_en(branch_en), .branch_add(branch_add),
        .mem_data(mem_data), .mem_add(mem_add_s), .ir(ir_s), .ir_valid(ir_valid_s),
        .busy(busy_s), .done(done_s), .instr_cnt(instr_cnt_s)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data for an address arrives one cycle later.
    always @(posedge clk) mem_data <= mem[mem_add];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Program-level reference: what the sequencer must do on each rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_pc = 8'd0; m_ir = 8'd0; m_v = 1'b0; m_cnt = 0;
        end else begin
            m_v = 1'b0;
            if (m_ph != 0 && !power) begin
                m_ph = 0; m_pc = 8'd0; m_cnt = 0;
            end else begin
                case (m_ph)
                    0: begin
                        m_pc = 8'd0; m_cnt = 0;
                        if (power) m_ph = 1;
                    end
                    1: if (!stall) m_ph = 2;
                    2: if (!stall) begin
                        m_ir = mem[m_pc];
                        m_v  = 1'b1;
                        if (m_cnt < 65535) m_cnt = m_cnt + 1;
                        if (branch_en) begin
                            m_pc = branch_add; m_ph = 1;
                        end else if (m_pc == last_add) begin
                            m_ph = 3;
                        end else begin
                            m_pc = 8'(m_pc + 8'd1); m_ph = 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_add", 32'(mem_add), 32'(m_pc));
            chk("ir", 32'(ir), 32'(m_ir));
            chk("ir_valid", 32'(ir_valid), 32'(m_v));
            chk("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
            chk("done", 32'(done), 32'(m_ph == 3));
            chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
            chk("instr_cnt_sat", 32'(instr_cnt_s), 32'((m_cnt > 3) ? 3 : m_cnt));
            chk("mem_add_s", 32'(mem_add_s), 32'(m_pc));
        end
    end

    // Runs one program from IDLE and logs each capture (address, data, cycle).
    task automatic run_prog(input logic [7:0] last, input int st_at, input int st_len,
                            input int br_at, input logic [7:0] br_tgt);
        logic [7:0] prev;
        int c;
        for (int i = 0; i < 16; i++) begin
            log_add[i] = 8'd0; log_ir[i] = 8'd0; log_cyc[i] = 0;
        end
        log_n = 0; c = 0;
        last_add = last; branch_add = br_tgt; power = 1'b1;
        prev = mem_add;
        while (!done && c < 80) begin
            step();
            c++;
            if (ir_valid && log_n < 16) begin
                log_add[log_n] = prev; log_ir[log_n] = ir; log_cyc[log_n] = c;
                log_n++;
            end
            prev = mem_add;
            stall = (c >= st_at) && (c < st_at + st_len);
            branch_en = (c == br_at);
        end
        chk("halt_reached", 32'(done), 32'd1);
    endtask

    task automatic stop_prog();
        power = 1'b0; stall = 1'b0; branch_en = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [7:0] e_add [4];
        logic [7:0] e_ir  [4];
        int         e_cyc [3];

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h01; mem[1] = 8'h13; mem[2] = 8'h3C; mem[3] = 8'h77;
        mem[4] = 8'hA4; mem[5] = 8'h5B; mem[255] = 8'hEE;

        // Reset state
        step();
        step();
        reset = 1'b0;
        step();
        chk_en = 1'b1;
        chk("rst_mem_add", 32'(mem_add), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_busy_done", 32'({busy, done, ir_valid}), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);

        // Straight-line three-instruction program
        run_prog(8'd2, 0, 0, -1, 8'd0);
        e_add = '{8'h00, 8'h01, 8'h02, 8'h00};
        e_ir  = '{8'h01, 8'h13, 8'h3C, 8'h00};
        chk("p1_count", 32'(log_n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("p1_addr", 32'(log_add[i]), 32'(e_add[i]));
            chk("p1_ir", 32'(log_ir[i]), 32'(e_ir[i]));
        end
        chk("p1_first_latency", 32'(log_cyc[0]), 32'd3);
        chk("p1_cnt", 32'(instr_cnt), 32'd3);
        chk("p1_done", 32'(done), 32'd1);
        stop_prog();

        // Same program, four stall cycles during the latch of address 1
        run_prog(8'd2, 4, 4, -1, 8'd0);
        e_cyc = '{3, 9, 11};
        chk("p2_count", 32'(log_n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("p2_ir", 32'(log_ir[i]), 32'(e_ir[i]));
            chk("p2_cycle", 32'(log_cyc[i]), 32'(e_cyc[i]));
        end
        stop_prog();

        // Branch from address 1 to 4, ending at 5
        run_prog(8'd5, 0, 0, 4, 8'd4);
        e_add = '{8'h00, 8'h01, 8'h04, 8'h05};
        e_ir  = '{8'h01, 8'h13, 8'hA4, 8'h5B};
        chk("p3_count", 32'(log_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("p3_addr", 32'(log_add[i]), 32'(e_add[i]));
            chk("p3_ir", 32'(log_ir[i]), 32'(e_ir[i]));
        end
        chk("p3_cnt", 32'(instr_cnt), 32'd4);
        stop_prog();

        // Branch to FF wraps through 00 to the last address 01
        run_prog(8'd1, 0, 0, 2, 8'hFF);
        e_add = '{8'h00, 8'hFF, 8'h00, 8'h01};
        e_ir  = '{8'h01, 8'hEE, 8'h01, 8'h13};
        chk("p4_count", 32'(log_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("p4_addr", 32'(log_add[i]), 32'(e_add[i]));
            chk("p4_ir", 32'(log_ir[i]), 32'(e_ir[i]));
        end
        stop_prog();

        // Five instructions: the 2-bit counter saturates at 3
        run_prog(8'd4, 0, 0, -1, 8'd0);
        chk("p5_count", 32'(log_n), 32'd5);
        chk("p5_cnt16", 32'(instr_cnt), 32'd5);
        chk("p5_cnt2", 32'(instr_cnt_s), 32'd3);
        stop_prog();

        // Asynchronous reset between edges while fetching address 1
        power = 1'b1;
        step(); step(); step();
        #1 reset = 1'b1;
        #1;
        chk("arst_mem_add", 32'(mem_add), 32'd0);
        chk("arst_ir", 32'(ir), 32'd0);
        chk("arst_ir_valid", 32'(ir_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_cnt", 32'(instr_cnt), 32'd0);
        reset = 1'b0;
        power = 1'b0;
        step(); step();
        chk("arst_idle_wait", 32'({busy, mem_add}), 32'd0);

        // Power removed during a latch: no capture, back to idle
        power = 1'b1;
        step(); step();
        power = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pwroff_ir_valid", 32'(ir_valid), 32'd0);
        end
        chk("pwroff_busy", 32'(busy), 32'd0);
        chk("pwroff_cnt", 32'(instr_cnt), 32'd0);

        // Randomized control over a random program
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            power      = ($urandom_range(0, 24) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            branch_en  = ($urandom_range(0, 7) == 0);
            branch_add = 8'($urandom);
            if ($urandom_range(0, 49) == 0) last_add = 8'($urandom_range(0, 15));
            step();
        end
        reset = 1'b0;
        stop_prog();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
